// File: rtl/rhythm_lanes_if.sv
// rhythm_lanes_if: player-side and display-side signals of the rhythm lane core.
//   btn       - lane buttons, active-low, asynchronous to the core clock
//   speed_sel - global speed multiplier, 0 freezes note motion
//   row/col   - current VGA raster position, pixel_en high in the visible area
//   r/g/b     - registered pixel colour
//   score/miss/error - saturating binary event counters for the BCD display
// The master modport is the driver of the inputs (VGA timing, buttons);
// the slave modport is the game core.
interface rhythm_lanes_if #(
  parameter int LANES = 4
);
  logic [LANES-1:0] btn;
  logic [3:0]       speed_sel;
  logic [9:0]       row;
  logic [9:0]       col;
  logic             pixel_en;
  logic [7:0]       r;
  logic [7:0]       g;
  logic [7:0]       b;
  logic [7:0]       score;
  logic [7:0]       miss;
  logic [7:0]       error;

  modport master (
    output btn, speed_sel, row, col, pixel_en,
    input  r, g, b, score, miss, error
  );

  modport slave (
    input  btn, speed_sel, row, col, pixel_en,
    output r, g, b, score, miss, error
  );
endinterface

// File: rtl/rhythm_lanes.sv
// rhythm_lanes: falling-note game core with LANES lanes.
// Notes spawn pseudo-randomly on movement ticks, fall at a per-note speed
// scaled by speed_sel, and are scored when the lane button is pressed while
// the note is inside the hit window. Late notes count as misses, presses with
// nothing to hit count as errors. Pixel colours are produced with one clock of
// latency from row/col.
// Ports:
//   clk   - system clock
//   reset - asynchronous active-high reset
//   bus   - rhythm_lanes_if slave modport (buttons, speed, raster in;
//           colour and counters out)
module rhythm_lanes #(
  parameter int          LANES       = 4,
  parameter int          LANE_W      = 160,
  parameter int          BORDER      = 20,
  parameter int          NOTE_H      = 70,
  parameter int          HIT_LO      = 350,
  parameter int          MISS_ROW    = 500,
  parameter int          BAR_TOP     = 420,
  parameter int          BAR_BOT     = 430,
  parameter int          TICK_DIV    = 2500000,
  parameter int          SPAWN_RATE  = 8,
  parameter int          FLASH_TICKS = 6,
  parameter logic [19:0] SEED        = 20'h1E240,
  parameter int          MAX_COUNT   = 99
) (
  input logic          clk,
  input logic          reset,
  rhythm_lanes_if.slave bus
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FL_W  = (FLASH_TICKS > 0) ? $clog2(FLASH_TICKS + 1) : 1;

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [10:0] HIT_LO_V  = 11'(HIT_LO);
  localparam logic [10:0] MISS_V    = 11'(MISS_ROW);
  localparam logic [10:0] BAR_TOP_V = 11'(BAR_TOP);
  localparam logic [10:0] BAR_BOT_V = 11'(BAR_BOT);
  localparam logic [10:0] NOTE_H_V  = 11'(NOTE_H);
  localparam logic [10:0] PLAY_W_V  = 11'(LANES * LANE_W);
  localparam logic [10:0] LANE_W_V  = 11'(LANE_W);
  localparam logic [10:0] BORDER_V  = 11'(BORDER);
  localparam logic [10:0] INNER_V   = 11'(LANE_W - BORDER);
  localparam logic [8:0]  SPAWN_V   = 9'(SPAWN_RATE);
  localparam logic [FL_W-1:0] FLASH_V = FL_W'(FLASH_TICKS);
  localparam logic [7:0]  MAX_V     = 8'(MAX_COUNT);

  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic [19:0]      lfsr;

  logic [LANES-1:0] btn_s1, btn_s2, btn_s3;
  logic [LANES-1:0] press;

  logic [LANES-1:0] active;
  logic [9:0]       pos   [LANES];
  logic [1:0]       speed [LANES];
  logic [FL_W-1:0]  flash [LANES];

  logic [10:0]      next_sum [LANES];
  logic [LANES-1:0] hit, miss_ev, err_ev, spawn_ev;
  logic             spawn_fire;
  logic [7:0]       spawn_idx;
  logic [1:0]       spawn_speed;

  logic [7:0] score_q, miss_q, error_q;
  logic [7:0] r_q, g_q, b_q;
  logic [7:0] pix_r, pix_g, pix_b;

  function automatic logic [3:0] count_ones(input logic [LANES-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) n = n + {3'd0, v[i]};
    return n;
  endfunction

  // Counters stay pinned at MAX_COUNT once reached, whatever k is.
  function automatic logic [7:0] sat_add(input logic [7:0] c, input logic [3:0] k);
    logic [8:0] s;
    s = {1'b0, c} + {5'd0, k};
    return (s >= {1'b0, MAX_V}) ? MAX_V : s[7:0];
  endfunction

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= SEED;
    else lfsr <= {lfsr[18:0], lfsr[19] ^ lfsr[16]};
  end

  // Synchronisers start released so a button held through reset does not
  // register as a press; btn_s3 only remembers the previous synced level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_s1 <= '1;
      btn_s2 <= '1;
      btn_s3 <= '1;
    end else begin
      btn_s1 <= bus.btn;
      btn_s2 <= btn_s1;
      btn_s3 <= btn_s2;
    end
  end

  assign press = btn_s3 & ~btn_s2;

  always_comb begin
    spawn_fire  = tick && ({1'b0, lfsr[7:0]} < SPAWN_V);
    spawn_idx   = lfsr[15:8] % 8'(LANES);
    spawn_speed = 2'd1 + ((lfsr[17:16] == 2'd3) ? 2'd0 : lfsr[17:16]);
  end

  // Event decode per lane. A hit suppresses the miss of the same cycle, and
  // spawns only target idle lanes so they can never collide with a hit.
  // next_sum keeps an 11th bit so an overflow past 1023 is seen as a miss.
  always_comb begin
    hit      = '0;
    miss_ev  = '0;
    err_ev   = '0;
    spawn_ev = '0;
    for (int i = 0; i < LANES; i++) begin
      next_sum[i] = {1'b0, pos[i]} + ({9'd0, speed[i]} * {7'd0, bus.speed_sel});
      hit[i]      = press[i] && active[i] &&
                    ({1'b0, pos[i]} >= HIT_LO_V) && ({1'b0, pos[i]} < MISS_V);
      err_ev[i]   = press[i] && !hit[i];
      miss_ev[i]  = tick && active[i] && !hit[i] &&
                    ((next_sum[i] >= MISS_V) || next_sum[i][10]);
      spawn_ev[i] = spawn_fire && (spawn_idx == 8'(i)) && !active[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active <= '0;
      for (int i = 0; i < LANES; i++) begin
        pos[i]   <= '0;
        speed[i] <= '0;
        flash[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (hit[i]) begin
          active[i] <= 1'b0;
          flash[i]  <= FLASH_V;
        end else begin
          if (tick && (flash[i] != '0)) flash[i] <= flash[i] - 1'b1;
          if (miss_ev[i]) begin
            active[i] <= 1'b0;
          end else if (tick && active[i]) begin
            pos[i] <= next_sum[i][9:0];
          end else if (spawn_ev[i]) begin
            active[i] <= 1'b1;
            pos[i]    <= 10'd1;
            speed[i]  <= spawn_speed;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_q <= '0;
      miss_q  <= '0;
      error_q <= '0;
    end else begin
      score_q <= sat_add(score_q, count_ones(hit));
      miss_q  <= sat_add(miss_q,  count_ones(miss_ev));
      error_q <= sat_add(error_q, count_ones(err_ev));
    end
  end

  // Pixel colour for the lane under the current column, in priority order.
  always_comb begin
    logic [10:0] col_x;
    logic [10:0] row_x;
    logic [10:0] lane_off;
    logic [3:0]  lane_sel;
    logic        sel_active;
    logic [10:0] sel_pos;
    logic        sel_flash;
    col_x      = {1'b0, bus.col};
    row_x      = {1'b0, bus.row};
    lane_sel   = 4'(col_x / LANE_W_V);
    lane_off   = col_x % LANE_W_V;
    sel_active = 1'b0;
    sel_pos    = '0;
    sel_flash  = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_sel == 4'(i)) begin
        sel_active = active[i];
        sel_pos    = {1'b0, pos[i]};
        sel_flash  = (flash[i] != '0);
      end
    end
    pix_r = 8'd0;
    pix_g = 8'd0;
    pix_b = 8'd0;
    if (!bus.pixel_en || (col_x >= PLAY_W_V)) begin
      pix_r = 8'd0;
    end else if ((lane_off < BORDER_V) || (lane_off >= INNER_V)) begin
      pix_b = 8'd100;
    end else if ((row_x >= BAR_TOP_V) && (row_x <= BAR_BOT_V)) begin
      pix_g = 8'd100;
    end else if (sel_active && (row_x >= sel_pos) && (row_x < sel_pos + NOTE_H_V)) begin
      pix_r = 8'd100;
    end else if (sel_flash) begin
      pix_r = 8'd60;
      pix_g = 8'd60;
      pix_b = 8'd60;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
    end else begin
      r_q <= pix_r;
      g_q <= pix_g;
      b_q <= pix_b;
    end
  end

  assign bus.r     = r_q;
  assign bus.g     = g_q;
  assign bus.b     = b_q;
  assign bus.score = score_q;
  assign bus.miss  = miss_q;
  assign bus.error = error_q;

endmodule

// File: tb/tb_rhythm_lanes.sv
// tb_rhythm_lanes: randomized play against a behavioural model of the game
// rules (lane records, button history, saturating totals, pixel priority).
module tb_rhythm_lanes;
  localparam int LANES       = 4;
  localparam int LANE_W      = 160;
  localparam int BORDER      = 20;
  localparam int NOTE_H      = 70;
  localparam int HIT_LO      = 350;
  localparam int MISS_ROW    = 500;
  localparam int BAR_TOP     = 420;
  localparam int BAR_BOT     = 430;
  localparam int TICK_DIV    = 4;
  localparam int SPAWN_RATE  = 48;
  localparam int FLASH_TICKS = 6;
  localparam int MAX_COUNT   = 60;
  localparam logic [19:0] SEED = 20'h1E240;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rhythm_lanes_if #(.LANES(LANES)) bus ();

  rhythm_lanes #(
    .LANES(LANES), .LANE_W(LANE_W), .BORDER(BORDER), .NOTE_H(NOTE_H),
    .HIT_LO(HIT_LO), .MISS_ROW(MISS_ROW), .BAR_TOP(BAR_TOP), .BAR_BOT(BAR_BOT),
    .TICK_DIV(TICK_DIV), .SPAWN_RATE(SPAWN_RATE), .FLASH_TICKS(FLASH_TICKS),
    .SEED(SEED), .MAX_COUNT(MAX_COUNT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  bit               m_active [LANES];
  int               m_pos    [LANES];
  int               m_speed  [LANES];
  int               m_flash  [LANES];
  int               m_score, m_miss, m_err, m_cnt;
  logic [19:0]      m_lfsr;
  logic [LANES-1:0] m_hist [$];
  int               exp_r, exp_g, exp_b;
  int               checks = 0;
  int               errors = 0;
  int               cycle  = 0;

  function automatic int sat(input int v);
    return (v > MAX_COUNT) ? MAX_COUNT : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LANES; i++) begin
      m_active[i] = 1'b0;
      m_pos[i]    = 0;
      m_speed[i]  = 0;
      m_flash[i]  = 0;
    end
    m_score = 0;
    m_miss  = 0;
    m_err   = 0;
    m_cnt   = 0;
    m_lfsr  = SEED;
    m_hist.delete();
    repeat (3) m_hist.push_back({LANES{1'b1}});
  endtask

  // Applies one clock of game rules to the model with the current inputs,
  // then advances the real clock. exp_* is what the registered pixel shows.
  task automatic model_clock();
    int c, rw, ln, off, tgt, np, nhit, nmiss, nerr;
    bit tick, fire;
    bit was_idle [LANES];
    logic [LANES-1:0] pr;
    c = int'(bus.col);
    rw = int'(bus.row);
    ln = c / LANE_W;
    off = c % LANE_W;
    exp_r = 0; exp_g = 0; exp_b = 0;
    if (!bus.pixel_en || c >= LANES * LANE_W) exp_r = 0;
    else if (off < BORDER || off >= LANE_W - BORDER) exp_b = 100;
    else if (rw >= BAR_TOP && rw <= BAR_BOT) exp_g = 100;
    else if (m_active[ln] && rw >= m_pos[ln] && rw < m_pos[ln] + NOTE_H) exp_r = 100;
    else if (m_flash[ln] != 0) begin exp_r = 60; exp_g = 60; exp_b = 60; end

    tick = (m_cnt == TICK_DIV - 1);
    m_cnt = tick ? 0 : m_cnt + 1;
    pr = m_hist[2] & ~m_hist[1];
    fire = tick && (int'(m_lfsr[7:0]) < SPAWN_RATE);
    tgt = int'(m_lfsr[15:8]) % LANES;
    for (int i = 0; i < LANES; i++) was_idle[i] = !m_active[i];
    nhit = 0; nmiss = 0; nerr = 0;
    for (int i = 0; i < LANES; i++) begin
      if (pr[i] && m_active[i] && m_pos[i] >= HIT_LO && m_pos[i] < MISS_ROW) begin
        nhit++;
        m_active[i] = 1'b0;
        m_flash[i] = FLASH_TICKS;
      end else begin
        if (pr[i]) nerr++;
        if (tick && m_flash[i] > 0) m_flash[i]--;
        if (tick && m_active[i]) begin
          np = m_pos[i] + m_speed[i] * int'(bus.speed_sel);
          if (np >= MISS_ROW || np > 1023) begin
            nmiss++;
            m_active[i] = 1'b0;
          end else m_pos[i] = np;
        end else if (fire && tgt == i && was_idle[i]) begin
          m_active[i] = 1'b1;
          m_pos[i] = 1;
          m_speed[i] = 1 + int'(m_lfsr[17:16]) % 3;
        end
      end
    end
    m_score = sat(m_score + nhit);
    m_miss  = sat(m_miss + nmiss);
    m_err   = sat(m_err + nerr);
    m_lfsr  = {m_lfsr[18:0], m_lfsr[19] ^ m_lfsr[16]};
    m_hist.push_front(bus.btn);
    void'(m_hist.pop_back());
    @(posedge clk);
    #1;
    cycle++;
  endtask

  // Presses favour lanes whose note is near the hit window; other lanes are
  // pressed rarely so wrong presses still occur.
  task automatic drive_buttons(input int press_div);
    for (int i = 0; i < LANES; i++) begin
      if (!bus.btn[i]) bus.btn[i] = ($urandom_range(0, 1) != 0);
      else if (m_active[i] && m_pos[i] >= HIT_LO - 40 && m_pos[i] < MISS_ROW)
        bus.btn[i] = ($urandom_range(0, 2) != 0);
      else bus.btn[i] = ($urandom_range(0, press_div - 1) != 0);
    end
  endtask

  task automatic drive_pixels();
    int ln, c, rw;
    if ($urandom_range(0, 1) != 0) begin
      ln = int'($urandom_range(0, LANES - 1));
      c  = ln * LANE_W + int'($urandom_range(0, LANE_W - 1));
      rw = m_pos[ln] + int'($urandom_range(0, 90)) - 10;
      if (rw < 0) rw = 0;
      if (rw > 1023) rw = 1023;
    end else begin
      c  = int'($urandom_range(0, 1023));
      rw = int'($urandom_range(0, 1023));
    end
    bus.col = 10'(c);
    bus.row = 10'(rw);
    bus.pixel_en = ($urandom_range(0, 9) != 0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.btn = '1;
    bus.speed_sel = 4'd0;
    bus.row = '0;
    bus.col = '0;
    bus.pixel_en = 1'b0;
    #1;
    checks++;
    if ({bus.r, bus.g, bus.b, bus.score, bus.miss, bus.error} !== 48'd0) begin
      errors++;
      $display("[TB] FAIL reset_initial got %h required 0",
               {bus.r, bus.g, bus.b, bus.score, bus.miss, bus.error});
    end
    repeat (3) begin
      bus.pixel_en = 1'b1;
      bus.col = 10'd10;
      @(posedge clk);
      #1;
      checks++;
      if ({bus.r, bus.g, bus.b, bus.score, bus.miss, bus.error} !== 48'd0) begin
        errors++;
        $display("[TB] FAIL reset_hold got %h required 0",
                 {bus.r, bus.g, bus.b, bus.score, bus.miss, bus.error});
      end
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_random_play(input int n);
    for (int k = 0; k < n; k++) begin
      if (k % 100 == 0) bus.speed_sel = 4'($urandom_range(0, 15));
      drive_buttons(40);
      drive_pixels();
      model_clock();
      checks++;
      if ({bus.score, bus.miss, bus.error} !== {8'(m_score), 8'(m_miss), 8'(m_err)}) begin
        errors++;
        $display("[TB] FAIL play_counters cyc=%0d got s=%0d m=%0d e=%0d required s=%0d m=%0d e=%0d",
                 cycle, bus.score, bus.miss, bus.error, m_score, m_miss, m_err);
      end
      checks++;
      if ({bus.r, bus.g, bus.b} !== {8'(exp_r), 8'(exp_g), 8'(exp_b)}) begin
        errors++;
        $display("[TB] FAIL play_pixel cyc=%0d got %0d/%0d/%0d required %0d/%0d/%0d",
                 cycle, bus.r, bus.g, bus.b, exp_r, exp_g, exp_b);
      end
    end
  endtask

  task automatic test_pause(input int n);
    int miss_start;
    bus.speed_sel = 4'd0;
    miss_start = m_miss;
    for (int k = 0; k < n; k++) begin
      drive_buttons(20);
      drive_pixels();
      model_clock();
      checks++;
      if ({bus.score, bus.miss, bus.error} !== {8'(m_score), 8'(m_miss), 8'(m_err)}) begin
        errors++;
        $display("[TB] FAIL pause_counters cyc=%0d got s=%0d m=%0d e=%0d required s=%0d m=%0d e=%0d",
                 cycle, bus.score, bus.miss, bus.error, m_score, m_miss, m_err);
      end
      checks++;
      if ({bus.r, bus.g, bus.b} !== {8'(exp_r), 8'(exp_g), 8'(exp_b)}) begin
        errors++;
        $display("[TB] FAIL pause_pixel cyc=%0d got %0d/%0d/%0d required %0d/%0d/%0d",
                 cycle, bus.r, bus.g, bus.b, exp_r, exp_g, exp_b);
      end
    end
    checks++;
    if (int'(bus.miss) !== miss_start) begin
      errors++;
      $display("[TB] FAIL pause_no_miss got %0d required %0d", bus.miss, miss_start);
    end
  endtask

  task automatic test_reset_midgame();
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.r, bus.g, bus.b, bus.score, bus.miss, bus.error} !== 48'd0) begin
      errors++;
      $display("[TB] FAIL midreset_async got %h required 0",
               {bus.r, bus.g, bus.b, bus.score, bus.miss, bus.error});
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus.r, bus.g, bus.b, bus.score, bus.miss, bus.error} !== 48'd0) begin
      errors++;
      $display("[TB] FAIL midreset_hold got %h required 0",
               {bus.r, bus.g, bus.b, bus.score, bus.miss, bus.error});
    end
    bus.btn = '1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_hold_button();
    int base;
    bus.speed_sel = 4'd0;
    bus.btn = '1;
    repeat (3) model_clock();
    base = m_score + m_err;
    bus.btn[3] = 1'b0;
    for (int k = 0; k < 50; k++) begin
      drive_pixels();
      model_clock();
      checks++;
      if ({bus.score, bus.miss, bus.error} !== {8'(m_score), 8'(m_miss), 8'(m_err)}) begin
        errors++;
        $display("[TB] FAIL hold_counters cyc=%0d got s=%0d m=%0d e=%0d required s=%0d m=%0d e=%0d",
                 cycle, bus.score, bus.miss, bus.error, m_score, m_miss, m_err);
      end
    end
    checks++;
    if (int'(bus.score) + int'(bus.error) !== base + 1) begin
      errors++;
      $display("[TB] FAIL hold_one_event got %0d required %0d",
               int'(bus.score) + int'(bus.error), base + 1);
    end
    bus.btn = '1;
  endtask

  task automatic test_simultaneous();
    int base;
    bus.speed_sel = 4'd0;
    bus.btn = '1;
    repeat (3) model_clock();
    base = m_score + m_err;
    bus.btn = '0;
    for (int k = 0; k < 6; k++) begin
      drive_pixels();
      model_clock();
      checks++;
      if ({bus.score, bus.miss, bus.error} !== {8'(m_score), 8'(m_miss), 8'(m_err)}) begin
        errors++;
        $display("[TB] FAIL simul_counters cyc=%0d got s=%0d m=%0d e=%0d required s=%0d m=%0d e=%0d",
                 cycle, bus.score, bus.miss, bus.error, m_score, m_miss, m_err);
      end
    end
    checks++;
    if (int'(bus.score) + int'(bus.error) !== base + LANES) begin
      errors++;
      $display("[TB] FAIL simul_popcount got %0d required %0d",
               int'(bus.score) + int'(bus.error), base + LANES);
    end
    bus.btn = '1;
  endtask

  initial begin
    test_reset();
    test_random_play(2500);
    test_pause(300);
    test_reset_midgame();
    test_hold_button();
    test_simultaneous();
    test_random_play(1500);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
